// File: rtl/multi_phase_light_fsm_pkg.sv
// Shared definitions for the multi-phase traffic-light controller:
// state encoding, interval-register select codes and LED bit offsets
// inside each phase's {R,Y,G} triple.
package multi_phase_light_fsm_pkg;

    // Controller states; one interval register is loaded on entry to each.
    typedef enum logic [1:0] {
        ST_GREEN     = 2'd0,
        ST_GREEN_EXT = 2'd1,
        ST_YELLOW    = 2'd2,
        ST_WALK      = 2'd3
    } light_state_t;

    // prog_sel / timer select codes
    localparam logic [1:0] SEL_BASE = 2'd0;
    localparam logic [1:0] SEL_EXT  = 2'd1;
    localparam logic [1:0] SEL_YEL  = 2'd2;
    localparam logic [1:0] SEL_WALK = 2'd3;

    // Bit offsets inside a phase's 3-bit LED group
    localparam int unsigned LED_R = 2;
    localparam int unsigned LED_Y = 1;
    localparam int unsigned LED_G = 0;

endpackage

// File: rtl/multi_phase_light_fsm_timer.sv
// light_interval_timer: four programmable interval registers plus the
// down-counter that times the current controller state.
// Ports:
//   clk, Reset_Sync      clock, synchronous active-high reset
//   prog                 program strobe: write register, restart at base interval
//   prog_sel, prog_val   register select and value for prog
//   load, sel            load counter from interval register sel (state entry)
//   tick                 one time unit elapsed
//   expire               combinational: this tick ends the current state
module light_interval_timer
    import multi_phase_light_fsm_pkg::*;
#(
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned T_BASE = 6,
    parameter int unsigned T_EXT  = 3,
    parameter int unsigned T_YEL  = 2,
    parameter int unsigned T_WALK = 3
) (
    input  logic             clk,
    input  logic             Reset_Sync,
    input  logic             prog,
    input  logic [1:0]       prog_sel,
    input  logic [CNT_W-1:0] prog_val,
    input  logic             load,
    input  logic [1:0]       sel,
    input  logic             tick,
    output logic             expire
);

    logic [CNT_W-1:0] interval [4];
    logic [CNT_W-1:0] cnt;

    // A zero interval would never expire; run it as one tick instead.
    function automatic logic [CNT_W-1:0] at_least_one(input logic [CNT_W-1:0] v);
        return (v == '0) ? CNT_W'(1) : v;
    endfunction

    // Interval register file and countdown; prog restarts at the base interval,
    // using the new value when the base register itself is being written.
    always_ff @(posedge clk) begin
        if (Reset_Sync) begin
            interval[SEL_BASE] <= CNT_W'(T_BASE);
            interval[SEL_EXT]  <= CNT_W'(T_EXT);
            interval[SEL_YEL]  <= CNT_W'(T_YEL);
            interval[SEL_WALK] <= CNT_W'(T_WALK);
            cnt                <= at_least_one(CNT_W'(T_BASE));
        end else if (prog) begin
            interval[prog_sel] <= prog_val;
            cnt <= at_least_one((prog_sel == SEL_BASE) ? prog_val : interval[SEL_BASE]);
        end else if (load) begin
            cnt <= at_least_one(interval[sel]);
        end else if (tick && (cnt != CNT_W'(1))) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // Last tick of the interval: a state programmed to T lasts exactly T ticks.
    assign expire = tick && (cnt == CNT_W'(1));

endmodule

// File: rtl/multi_phase_light_fsm.sv
// multi_phase_light_fsm: round-robin traffic-light controller for N_PHASES
// green phases with optional green extension, pedestrian walk phase and
// skip-empty mode, timed by light_interval_timer.
// Ports:
//   clk, Reset_Sync      clock, synchronous active-high reset
//   tick                 one-cycle pulse per time unit
//   Sensor_Sync          vehicle present, one bit per phase
//   WR                   latched walk request level
//   Prog_Sync            program strobe (write interval and restart)
//   prog_sel, prog_val   interval select / value for Prog_Sync
//   WR_Reset             one-cycle pulse clearing the walk latch on WALK entry
//   LEDs                 [3p+2:3p] = {R,Y,G} of phase p, [3*N_PHASES] = walk
//   phase                phase currently owning right-of-way
module multi_phase_light_fsm
    import multi_phase_light_fsm_pkg::*;
#(
    parameter int unsigned N_PHASES   = 3,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned T_BASE     = 6,
    parameter int unsigned T_EXT      = 3,
    parameter int unsigned T_YEL      = 2,
    parameter int unsigned T_WALK     = 3,
    parameter bit          SKIP_EMPTY = 1'b0,
    localparam int unsigned PH_W      = $clog2(N_PHASES)
) (
    input  logic                clk,
    input  logic                Reset_Sync,
    input  logic                tick,
    input  logic [N_PHASES-1:0] Sensor_Sync,
    input  logic                WR,
    input  logic                Prog_Sync,
    input  logic [1:0]          prog_sel,
    input  logic [CNT_W-1:0]    prog_val,
    output logic                WR_Reset,
    output logic [3*N_PHASES:0] LEDs,
    output logic [PH_W-1:0]     phase
);

    light_state_t       state_q, state_d;
    logic [PH_W-1:0]    phase_d;
    logic [PH_W-1:0]    nxt_q, nxt_d;
    logic [PH_W-1:0]    pick_c;
    logic [PH_W-1:0]    cand_c;
    logic               found_c;
    logic               rest_c;
    logic               wr_reset_d;
    logic               load_c;
    logic [1:0]         sel_c;
    logic               expire;

    light_interval_timer #(
        .CNT_W  (CNT_W),
        .T_BASE (T_BASE),
        .T_EXT  (T_EXT),
        .T_YEL  (T_YEL),
        .T_WALK (T_WALK)
    ) u_timer (
        .clk        (clk),
        .Reset_Sync (Reset_Sync),
        .prog       (Prog_Sync),
        .prog_sel   (prog_sel),
        .prog_val   (prog_val),
        .load       (load_c),
        .sel        (sel_c),
        .tick       (tick),
        .expire     (expire)
    );

    // Moore LED decode for a given state/phase pair.
    function automatic logic [3*N_PHASES:0] decode_leds(input light_state_t st,
                                                        input logic [PH_W-1:0] ph);
        logic [3*N_PHASES:0] v;
        v = '0;
        for (int unsigned p = 0; p < N_PHASES; p++) begin
            if ((st != ST_WALK) && (PH_W'(p) == ph)) begin
                if (st == ST_YELLOW) v[3*p + LED_Y] = 1'b1;
                else                 v[3*p + LED_G] = 1'b1;
            end else begin
                v[3*p + LED_R] = 1'b1;
            end
        end
        v[3*N_PHASES] = (st == ST_WALK);
        return v;
    endfunction

    // Next-phase selector: first candidate after the current phase in
    // round-robin order; in skip-empty mode only occupied phases or phase 0.
    always_comb begin
        found_c = 1'b0;
        pick_c  = '0;
        cand_c  = '0;
        for (int unsigned k = 1; k <= N_PHASES; k++) begin
            cand_c = PH_W'((32'(phase) + k) % N_PHASES);
            if (!found_c && (!SKIP_EMPTY || Sensor_Sync[cand_c] || (cand_c == '0))) begin
                found_c = 1'b1;
                pick_c  = cand_c;
            end
        end
        // Nothing waiting anywhere and no walk request: phase 0 keeps green.
        rest_c = SKIP_EMPTY && (pick_c == '0) && (phase == '0) && !WR;
    end

    // Next-state logic; every end-of-state reloads the timer for the new state.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase;
        nxt_d      = nxt_q;
        wr_reset_d = 1'b0;
        load_c     = 1'b0;
        sel_c      = SEL_BASE;
        if (expire) begin
            load_c = 1'b1;
            unique case (state_q)
                ST_GREEN, ST_GREEN_EXT: begin
                    if ((state_q == ST_GREEN) && Sensor_Sync[phase]) begin
                        state_d = ST_GREEN_EXT;
                        sel_c   = SEL_EXT;
                    end else if (rest_c) begin
                        state_d = ST_GREEN;
                        sel_c   = SEL_BASE;
                    end else begin
                        state_d = ST_YELLOW;
                        sel_c   = SEL_YEL;
                        nxt_d   = pick_c;
                    end
                end
                ST_YELLOW: begin
                    if (WR) begin
                        state_d    = ST_WALK;
                        sel_c      = SEL_WALK;
                        wr_reset_d = 1'b1;
                    end else begin
                        state_d = ST_GREEN;
                        phase_d = nxt_q;
                        sel_c   = SEL_BASE;
                    end
                end
                ST_WALK: begin
                    state_d = ST_GREEN;
                    phase_d = nxt_q;
                    sel_c   = SEL_BASE;
                end
            endcase
        end
    end

    // State and registered outputs; program strobe restarts like reset.
    always_ff @(posedge clk) begin
        if (Reset_Sync || Prog_Sync) begin
            state_q  <= ST_GREEN;
            phase    <= '0;
            nxt_q    <= '0;
            WR_Reset <= 1'b0;
            LEDs     <= decode_leds(ST_GREEN, '0);
        end else begin
            state_q  <= state_d;
            phase    <= phase_d;
            nxt_q    <= nxt_d;
            WR_Reset <= wr_reset_d;
            LEDs     <= decode_leds(state_d, phase_d);
        end
    end

endmodule

// File: tb/tb_multi_phase_light_fsm.sv
// Testbench for multi_phase_light_fsm: two instances (round-robin and
// skip-empty) share stimulus; directed scenarios plus randomized traffic
// checked against a duration-based reference model.
module tb_multi_phase_light_fsm;

    logic       clk = 1'b0;
    logic       rst, tick, wr, prog;
    logic [2:0] sensor;
    logic [1:0] psel;
    logic [7:0] pval;
    logic       wrr_a, wrr_b;
    logic [9:0] leds_a, leds_b;
    logic [1:0] ph_a, ph_b;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [9:0] G0 = 10'b0_100_100_001;
    localparam logic [9:0] Y0 = 10'b0_100_100_010;
    localparam logic [9:0] G1 = 10'b0_100_001_100;
    localparam logic [9:0] Y1 = 10'b0_100_010_100;
    localparam logic [9:0] G2 = 10'b0_001_100_100;
    localparam logic [9:0] Y2 = 10'b0_010_100_100;
    localparam logic [9:0] WK = 10'b1_100_100_100;

    always #5 clk = ~clk;

    multi_phase_light_fsm #(.N_PHASES(3), .CNT_W(8), .T_BASE(4), .T_EXT(2), .T_YEL(1),
                            .T_WALK(3), .SKIP_EMPTY(1'b0)) dut_a (
        .clk(clk), .Reset_Sync(rst), .tick(tick), .Sensor_Sync(sensor), .WR(wr),
        .Prog_Sync(prog), .prog_sel(psel), .prog_val(pval),
        .WR_Reset(wrr_a), .LEDs(leds_a), .phase(ph_a));

    multi_phase_light_fsm #(.N_PHASES(3), .CNT_W(8), .T_BASE(4), .T_EXT(2), .T_YEL(1),
                            .T_WALK(3), .SKIP_EMPTY(1'b1)) dut_b (
        .clk(clk), .Reset_Sync(rst), .tick(tick), .Sensor_Sync(sensor), .WR(wr),
        .Prog_Sync(prog), .prog_sel(psel), .prog_val(pval),
        .WR_Reset(wrr_b), .LEDs(leds_b), .phase(ph_b));

    // Reference model, index 0 = round-robin, 1 = skip-empty.
    // kind: 0 green, 1 extended green, 2 yellow, 3 walk; el counts ticks elapsed of dur.
    int m_kind [2];
    int m_ph   [2];
    int m_nx   [2];
    int m_el   [2];
    int m_dur  [2];
    int m_wrr  [2];
    int m_iv   [2][4];

    function automatic int eff(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    function automatic logic [9:0] exp_leds(input int kind, input int ph);
        logic [9:0] v;
        v = '0;
        for (int p = 0; p < 3; p++) begin
            if (kind != 3 && p == ph) v[3*p + ((kind == 2) ? 1 : 0)] = 1'b1;
            else                      v[3*p + 2] = 1'b1;
        end
        v[9] = (kind == 3);
        return v;
    endfunction

    function automatic int pick_next(input int ph, input bit skip, input logic [2:0] s);
        for (int k = 1; k <= 3; k++) begin
            int j;
            j = (ph + k) % 3;
            if (!skip || s[j] || j == 0) return j;
        end
        return 0;
    endfunction

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            m_wrr[k] = 0;
            if (rst) begin
                m_iv[k] = '{4, 2, 1, 3};
                m_kind[k] = 0; m_ph[k] = 0; m_nx[k] = 0; m_el[k] = 0; m_dur[k] = 4;
            end else if (prog) begin
                m_iv[k][psel] = int'(pval);
                m_kind[k] = 0; m_ph[k] = 0; m_el[k] = 0; m_dur[k] = eff(m_iv[k][0]);
            end else if (tick) begin
                if (m_el[k] + 1 < m_dur[k]) begin
                    m_el[k]++;
                end else begin
                    m_el[k] = 0;
                    if (m_kind[k] == 0 && sensor[m_ph[k]]) begin
                        m_kind[k] = 1; m_dur[k] = eff(m_iv[k][1]);
                    end else if (m_kind[k] <= 1) begin
                        int n;
                        n = pick_next(m_ph[k], (k == 1), sensor);
                        if (k == 1 && n == 0 && m_ph[k] == 0 && !wr) begin
                            m_kind[k] = 0; m_dur[k] = eff(m_iv[k][0]);
                        end else begin
                            m_kind[k] = 2; m_dur[k] = eff(m_iv[k][2]); m_nx[k] = n;
                        end
                    end else if (m_kind[k] == 2 && wr) begin
                        m_kind[k] = 3; m_dur[k] = eff(m_iv[k][3]); m_wrr[k] = 1;
                    end else begin
                        m_kind[k] = 0; m_ph[k] = m_nx[k]; m_dur[k] = eff(m_iv[k][0]);
                    end
                end
            end
        end
    endtask

    // One clock: model consumes the inputs seen at the edge; outputs sampled 1 unit later.
    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; tick = 1'b1; sensor = '0; wr = 1'b0; prog = 1'b0; psel = '0; pval = '0;
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        n_cmp++; if (leds_a !== G0) begin n_bad++; $display("FAIL reset_leds_a got %b want %b", leds_a, G0); end
        n_cmp++; if (ph_a !== 2'd0) begin n_bad++; $display("FAIL reset_phase_a got %0d want 0", ph_a); end
        n_cmp++; if (wrr_a !== 1'b0) begin n_bad++; $display("FAIL reset_wrr_a got %b want 0", wrr_a); end
        n_cmp++; if (leds_b !== G0) begin n_bad++; $display("FAIL reset_leds_b got %b want %b", leds_b, G0); end
    endtask

    // No sensors, no walk: 15-cycle round-robin; skip-empty instance rests in G0.
    task automatic test_round_robin();
        logic [9:0] gp [3];
        logic [9:0] yp [3];
        logic [9:0] want;
        int bad_b;
        gp[0] = G0; gp[1] = G1; gp[2] = G2;
        yp[0] = Y0; yp[1] = Y1; yp[2] = Y2;
        bad_b = 0;
        do_reset();
        for (int i = 0; i < 31; i++) begin
            want = ((i % 15) % 5 < 4) ? gp[(i % 15) / 5] : yp[(i % 15) / 5];
            n_cmp++;
            if (leds_a !== want) begin
                n_bad++; $display("FAIL rr_leds cyc %0d got %b want %b", i, leds_a, want);
            end
            if (leds_b !== G0) bad_b++;
            cyc();
        end
        n_cmp++; if (bad_b != 0) begin n_bad++; $display("FAIL skip_rest_g0 off-G0 samples got %0d want 0", bad_b); end
    endtask

    task automatic test_extension();
        int g;
        do_reset();
        sensor = 3'b001;
        g = 0;
        while (leds_a === G0 && g < 20) begin g++; cyc(); end
        sensor = 3'b000;
        n_cmp++; if (g != 6) begin n_bad++; $display("FAIL ext_green_len got %0d want 6", g); end
        n_cmp++; if (leds_a !== Y0) begin n_bad++; $display("FAIL ext_then_y0 got %b want %b", leds_a, Y0); end
    endtask

    task automatic test_walk();
        int guard, walk_n, wrr_n, bad_pat, wrr_first;
        bit done;
        do_reset();
        guard = 0;
        while (ph_a !== 2'd1 && guard < 20) begin guard++; cyc(); end
        n_cmp++; if (ph_a !== 2'd1) begin n_bad++; $display("FAIL walk_reach_g1 got %0d want 1", ph_a); end
        wr = 1'b1;
        walk_n = 0; wrr_n = 0; bad_pat = 0; wrr_first = 0; done = 0;
        for (int i = 0; i < 30 && !done; i++) begin
            cyc();
            if (leds_a[9]) begin
                walk_n++;
                if (leds_a !== WK) bad_pat++;
            end
            if (wrr_a) begin
                wrr_n++;
                if (walk_n == 1 && leds_a[9]) wrr_first = 1;
                wr = 1'b0;
            end
            if (walk_n > 0 && !leds_a[9]) done = 1;
        end
        n_cmp++; if (walk_n != 3) begin n_bad++; $display("FAIL walk_len got %0d want 3", walk_n); end
        n_cmp++; if (bad_pat != 0) begin n_bad++; $display("FAIL walk_leds bad samples got %0d want 0", bad_pat); end
        n_cmp++; if (wrr_n != 1 || wrr_first != 1) begin
            n_bad++; $display("FAIL walk_wr_reset pulses got %0d (on entry %0d) want 1 (1)", wrr_n, wrr_first);
        end
        n_cmp++; if (leds_a !== G2 || ph_a !== 2'd2) begin
            n_bad++; $display("FAIL walk_then_g2 got %b/%0d want %b/2", leds_a, ph_a, G2);
        end
        wr = 1'b0;
    endtask

    task automatic test_skip_empty();
        int bad, guard;
        do_reset();
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (leds_b !== G0) bad++;
            cyc();
        end
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL skip_hold off-G0 samples got %0d want 0", bad); end
        sensor = 3'b100;
        guard = 0;
        while (leds_b !== Y0 && guard < 10) begin guard++; cyc(); end
        n_cmp++; if (leds_b !== Y0) begin n_bad++; $display("FAIL skip_y0 got %b want %b", leds_b, Y0); end
        cyc();
        n_cmp++; if (leds_b !== G2 || ph_b !== 2'd2) begin
            n_bad++; $display("FAIL skip_to_g2 got %b/%0d want %b/2", leds_b, ph_b, G2);
        end
        sensor = 3'b000;
    endtask

    task automatic test_prog();
        int guard, g, y;
        do_reset();
        guard = 0;
        while (ph_a !== 2'd2 && guard < 20) begin guard++; cyc(); end
        cyc();
        prog = 1'b1; psel = 2'd2; pval = 8'd3;
        cyc();
        prog = 1'b0;
        n_cmp++; if (leds_a !== G0 || ph_a !== 2'd0) begin
            n_bad++; $display("FAIL prog_restart got %b/%0d want %b/0", leds_a, ph_a, G0);
        end
        g = 0;
        while (leds_a === G0 && g < 20) begin g++; cyc(); end
        y = 0;
        while (leds_a === Y0 && y < 20) begin y++; cyc(); end
        n_cmp++; if (g != 4) begin n_bad++; $display("FAIL prog_green_len got %0d want 4", g); end
        n_cmp++; if (y != 3) begin n_bad++; $display("FAIL prog_yellow_len got %0d want 3", y); end
    endtask

    task automatic test_reset_mid_walk();
        int guard;
        do_reset();
        wr = 1'b1;
        guard = 0;
        while (leds_a[9] !== 1'b1 && guard < 20) begin guard++; cyc(); end
        n_cmp++; if (leds_a[9] !== 1'b1) begin n_bad++; $display("FAIL rmw_reach_walk got %b want 1", leds_a[9]); end
        rst = 1'b1;
        cyc();
        rst = 1'b0; wr = 1'b0;
        n_cmp++; if (leds_a !== G0 || ph_a !== 2'd0) begin
            n_bad++; $display("FAIL rmw_state got %b/%0d want %b/0", leds_a, ph_a, G0);
        end
        n_cmp++; if (wrr_a !== 1'b0) begin n_bad++; $display("FAIL rmw_wr_reset got %b want 0", wrr_a); end
    endtask

    task automatic test_random();
        logic [9:0] al;
        logic [1:0] ap;
        logic       aw;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            tick   = ($urandom_range(0, 9) < 7);
            sensor = 3'($urandom);
            if ($urandom_range(0, 9) == 0) wr = ~wr;
            prog   = ($urandom_range(0, 99) == 0);
            psel   = 2'($urandom);
            pval   = 8'($urandom_range(0, 5));
            rst    = ($urandom_range(0, 299) == 0);
            cyc();
            for (int k = 0; k < 2; k++) begin
                al = (k == 0) ? leds_a : leds_b;
                ap = (k == 0) ? ph_a : ph_b;
                aw = (k == 0) ? wrr_a : wrr_b;
                n_cmp++; if (al !== exp_leds(m_kind[k], m_ph[k])) begin
                    n_bad++; $display("FAIL rnd_leds inst %0d cyc %0d got %b want %b", k, i, al, exp_leds(m_kind[k], m_ph[k]));
                end
                n_cmp++; if (ap !== 2'(m_ph[k])) begin
                    n_bad++; $display("FAIL rnd_phase inst %0d cyc %0d got %0d want %0d", k, i, ap, m_ph[k]);
                end
                n_cmp++; if (aw !== 1'(m_wrr[k])) begin
                    n_bad++; $display("FAIL rnd_wr_reset inst %0d cyc %0d got %b want %0d", k, i, aw, m_wrr[k]);
                end
            end
        end
        rst = 1'b0; prog = 1'b0; wr = 1'b0;
    endtask

    initial begin
        rst = 1'b1; tick = 1'b1; sensor = '0; wr = 1'b0; prog = 1'b0; psel = '0; pval = '0;
        #2;
        test_reset();
        test_round_robin();
        test_extension();
        test_walk();
        test_skip_empty();
        test_prog();
        test_reset_mid_walk();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
